wfq_div_pipe: RTL and testbench

Parametrised, fully pipelined non-restoring divider for the WFQ computation path. It computes the integer quotient of an unsigned integer (packet length) by an unsigned pure fraction (flow weight), one quotient bit per stage. It accepts one operation per cycle under a valid/ready handshake with global-stall backpressure, carries a sideband tag, and flags divide-by-zero and overflow with saturated results. It sits between the packet-length/weight lookup and the finish-time adder.

---
 rtl/wfq_div_pipe.sv | 135 +++++++++++++
 tb/tb_wfq_div_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wfq_div_pipe.sv
// Fully pipelined non-restoring divider: floor(dividend*2^WD / divisor), one quotient bit per stage.
// Optional remainder output and correction stage enabled by defining WFQ_DIV_REMAINDER_EN.
module wfq_div_pipe #(
  parameter int WN    = 16,
  parameter int WD    = 16,
  parameter int WQ    = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WN-1:0]    dividend,
  input  logic [WD-1:0]    divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WQ-1:0]    quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic             dz,
  output logic             ovf
`ifdef WFQ_DIV_REMAINDER_EN
  ,
  output logic [WD-1:0]    remainder
`endif
);

  localparam int RW = WD + 2;
  localparam int NW = WN + WD;
  localparam int CW = (NW > WD + WQ) ? NW : WD + WQ;

  // Stage 0 is the input register, stages 1..WQ each resolve one quotient bit.
  logic             s_v   [0:WQ];
  logic [RW-1:0]    s_r   [0:WQ];
  logic [WQ-1:0]    s_q   [0:WQ];
  logic [WD-1:0]    s_d   [0:WQ];
  logic [TAG_W-1:0] s_tag [0:WQ];
  logic             s_dz  [0:WQ];
  logic             s_ovf [0:WQ];

  logic [RW-1:0] it_r [1:WQ];
  logic [WQ-1:0] it_q [1:WQ];

  logic          advance;
  logic [NW-1:0] num;
  logic          in_dz;
  logic          in_ovf;
  logic [RW-1:0] in_r;
  logic [WQ-1:0] in_low;
  logic          unused_bits;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // The upper bits of dividend*2^WD seed the partial remainder; the low WQ bits
  // ride in the quotient register and are shifted out as quotient bits shift in.
  assign num    = {dividend, {WD{1'b0}}};
  assign in_dz  = (divisor == '0);
  assign in_ovf = !in_dz && (CW'(num) >= CW'({divisor, {WQ{1'b0}}}));
  assign in_r   = RW'({{RW{1'b0}}, num} >> WQ);
  assign in_low = num[WQ-1:0];

  always_comb begin
    for (int k = 1; k <= WQ; k++) begin
      it_r[k] = '0;
      it_q[k] = '0;
    end
    for (int k = 1; k <= WQ; k++) begin
      if (s_r[k-1][RW-1])
        it_r[k] = {s_r[k-1][RW-2:0], s_q[k-1][WQ-1]} + {2'b00, s_d[k-1]};
      else
        it_r[k] = {s_r[k-1][RW-2:0], s_q[k-1][WQ-1]} - {2'b00, s_d[k-1]};
      it_q[k] = {s_q[k-1][WQ-2:0], ~it_r[k][RW-1]};
    end
  end

`ifdef WFQ_DIV_REMAINDER_EN
  logic [RW-1:0] fix_r;

  // A negative final remainder only needs the divisor added back; quotient bits are already exact.
  assign fix_r       = s_r[WQ][RW-1] ? (s_r[WQ] + {2'b00, s_d[WQ]}) : s_r[WQ];
  assign unused_bits = ^fix_r[RW-1:WD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      remainder <= '0;
    else if (advance)
      remainder <= (s_dz[WQ] || s_ovf[WQ]) ? '0 : fix_r[WD-1:0];
  end
`else
  assign unused_bits = ^{s_r[WQ], s_d[WQ]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= WQ; k++) begin
        s_v[k]   <= 1'b0;
        s_r[k]   <= '0;
        s_q[k]   <= '0;
        s_d[k]   <= '0;
        s_tag[k] <= '0;
        s_dz[k]  <= 1'b0;
        s_ovf[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      quotient  <= '0;
      out_tag   <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      s_v[0]   <= in_valid;
      s_r[0]   <= in_r;
      s_q[0]   <= in_low;
      s_d[0]   <= divisor;
      s_tag[0] <= in_tag;
      s_dz[0]  <= in_dz;
      s_ovf[0] <= in_ovf;
      for (int k = 1; k <= WQ; k++) begin
        s_v[k]   <= s_v[k-1];
        s_r[k]   <= it_r[k];
        s_q[k]   <= it_q[k];
        s_d[k]   <= s_d[k-1];
        s_tag[k] <= s_tag[k-1];
        s_dz[k]  <= s_dz[k-1];
        s_ovf[k] <= s_ovf[k-1];
      end
      out_valid <= s_v[WQ];
      quotient  <= (s_dz[WQ] || s_ovf[WQ]) ? '1 : s_q[WQ];
      out_tag   <= s_tag[WQ];
      dz        <= s_dz[WQ];
      ovf       <= s_ovf[WQ];
    end
  end

endmodule

// File: tb/tb_wfq_div_pipe.sv
// Self-checking bench for wfq_div_pipe: vector table, random backpressure stream and mid-stream reset,
// with a scoreboard queue; remainder checks compiled in when WFQ_DIV_REMAINDER_EN is defined.
module tb_wfq_div_pipe;

  localparam int WQ = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  out_tag;
  logic        dz;
  logic        ovf;
`ifdef WFQ_DIV_REMAINDER_EN
  logic [15:0] remainder;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  tag;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  tag;
    logic        dz;
    logic        ovf;
    int          drive_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ready = 0;

  wfq_div_pipe #(.WN(16), .WD(16), .WQ(WQ), .TAG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .out_tag   (out_tag),
    .dz        (dz),
    .ovf       (ovf)
`ifdef WFQ_DIV_REMAINDER_EN
    ,
    .remainder (remainder)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Independent reference: exact integer division at 64 bits, then saturation rules.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag);
    exp_t e;
    longint n, q;
    e.tag = tag;
    e.chk_lat = 0;
    e.drive_cyc = 0;
    n = longint'(a) * 65536;
    e.dz = (b == 0);
    e.ovf = 0;
    e.q = 16'hFFFF;
    e.r = 16'h0;
    if (!e.dz) begin
      q = n / longint'(b);
      if (q >= 65536) e.ovf = 1;
      else begin
        e.q = q[15:0];
        e.r = 16'(n - q * longint'(b));
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag,
                               input exp_t e, input bit chk_lat);
    int guard = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    in_tag    = tag;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      e.drive_cyc = cyc;
      e.chk_lat = chk_lat;
      sb.push_back(e);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic waitDrain();
    int i = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && i < 300) begin
      @(negedge clk);
      #4;
      i++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every cycle checks in_ready against the stall rule and pops the scoreboard on each transfer.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got quotient=%0h tag=%0h, required none", quotient, out_tag);
        end else begin
          mon = sb.pop_front();
          checkOutput("quotient", 32'(quotient), 32'(mon.q));
          checkOutput("out_tag", 32'(out_tag), 32'(mon.tag));
          checkOutput("dz", 32'(dz), 32'(mon.dz));
          checkOutput("ovf", 32'(ovf), 32'(mon.ovf));
`ifdef WFQ_DIV_REMAINDER_EN
          checkOutput("remainder", 32'(remainder), 32'(mon.r));
`endif
          if (mon.chk_lat) checkOutput("latency", 32'(cyc - mon.drive_cyc), 32'(WQ + 2));
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic [15:0] a, b;

    vecs[0] = '{16'h0005, 16'h2600, 8'h10, 16'h0021, 16'h1A00, 1'b0, 1'b0};
    vecs[1] = '{16'h0011, 16'hC000, 8'h11, 16'h0016, 16'h8000, 1'b0, 1'b0};
    vecs[2] = '{16'h0014, 16'h8000, 8'h12, 16'h0028, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 16'h0000, 8'h13, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h0100, 16'h0001, 8'h14, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 16'h8000, 8'h15, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 8'h16, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 8'h17, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{16'h7FFF, 16'h8000, 8'h18, 16'hFFFE, 16'h0000, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 8'h19, 16'hFFFF, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    e = '{16'h0021, 16'h1A00, 8'hA1, 1'b0, 1'b0, 0, 0};
    applyStimulus(16'h0005, 16'h2600, 8'hA1, e, 1);
    waitDrain();

    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].dz, vecs[i].ovf, 0, 0};
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tag, e, 1);
    end
    waitDrain();

    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      b = 16'($urandom_range(1, 65535));
      a = 16'($urandom_range(0, int'(b) - 1));
      if (i % 4 == 3) a = 16'($urandom);
      if (i % 9 == 8) b = 16'h0000;
      if ($urandom_range(0, 3) == 0) idleCycle();
      applyStimulus(a, b, 8'(8'h40 + i), model(a, b, 8'(8'h40 + i)), 0);
    end
    rand_ready = 0;
    waitDrain();

    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].dz, vecs[i].ovf, 0, 0};
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tag, e, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_quotient", 32'(quotient), 32'd0);
    checkOutput("midreset_out_tag", 32'(out_tag), 32'd0);
    checkOutput("midreset_flags", 32'({dz, ovf}), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    e = '{16'h0021, 16'h1A00, 8'h5A, 1'b0, 1'b0, 0, 0};
    applyStimulus(16'h0005, 16'h2600, 8'h5A, e, 1);
    waitDrain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
